// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard scoreboard
package hazard_pkg;
    localparam int NREG = 32;
    typedef enum logic [1:0] {FWD_REG, FWD_E, FWD_M, FWD_W} fwd_sel_t;
    typedef struct packed {
        logic [4:0]  dst;
        logic        we;
        logic        long;
        logic [31:0] val;
    } stage_t;
endpackage

// File: rtl/hazard_fwd.sv
// hazard_fwd: operand forwarding select and RAW hazard flag for one D-stage source
// src/src_v/regval: source register, used flag, register-file value; br: D is a branch
// pend: scoreboard bit of src; e/m: E and M destination bundles; w_*: W destination
// val: resolved operand; haz: source must wait
module hazard_fwd
    import hazard_pkg::*;
#(
    parameter int BR_FWD_E = 0
) (
    input  logic [4:0]  src,
    input  logic        src_v,
    input  logic [31:0] regval,
    input  logic        br,
    input  logic        pend,
    input  stage_t      e,
    input  stage_t      m,
    input  logic [4:0]  w_dst,
    input  logic        w_we,
    input  logic [31:0] w_val,
    output logic [31:0] val,
    output logic        haz
);
    logic nz, e_hit, m_hit, w_hit, e_blk;
    fwd_sel_t sel;
    always_comb begin
        nz = src != 5'd0;
        e_hit = nz && e.we && e.dst == src;
        m_hit = nz && m.we && m.dst == src;
        w_hit = nz && w_we && w_dst == src;
        // E cannot supply a long result, nor feed a branch when that path is disabled
        e_blk = e.long || (br && BR_FWD_E == 0);
        sel = (e_hit && !e_blk) ? FWD_E : (m_hit && !m.long) ? FWD_M : w_hit ? FWD_W : FWD_REG;
        val = sel == FWD_E ? e.val : sel == FWD_M ? m.val : sel == FWD_W ? w_val : regval;
        // a pending long write is resolved once it reaches W, where it is forwarded
        haz = src_v && ((e_hit && e_blk) || (m_hit && m.long) || (nz && pend && !w_hit));
    end
endmodule

// File: rtl/hazard_sb.sv
// hazard_sb: pipeline hazard scoreboard with forwarding, stall/bubble control and MDU busy tracking
// inputs: ibus/dbus waits, D operand and destination info, E/M/W destination bundles, mdu_start
// outputs: fwd_val per source, stall_f/d/e/m, bubble_e/w, pending scoreboard, hilo_busy
module hazard_sb
    import hazard_pkg::*;
#(
    parameter int NSRC     = 2,
    parameter int MDU_LAT  = 32,
    parameter int BR_FWD_E = 0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 ibus_wait,
    input  logic                 dbus_wait,
    input  logic [NSRC-1:0][4:0]  d_src,
    input  logic [NSRC-1:0]       d_src_v,
    input  logic [NSRC-1:0][31:0] d_regval,
    input  logic                 d_br,
    input  logic                 d_hilo,
    input  logic [4:0]           d_dst,
    input  logic                 d_we,
    input  logic                 d_long,
    input  logic                 mdu_start,
    input  logic [4:0]           e_dst,
    input  logic                 e_we,
    input  logic                 e_long,
    input  logic [31:0]          e_val,
    input  logic [4:0]           m_dst,
    input  logic                 m_we,
    input  logic                 m_long,
    input  logic [31:0]          m_val,
    input  logic [4:0]           w_dst,
    input  logic                 w_we,
    input  logic                 w_long,
    input  logic [31:0]          w_val,
    output logic [NSRC-1:0][31:0] fwd_val,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 stall_e,
    output logic                 stall_m,
    output logic                 bubble_e,
    output logic                 bubble_w,
    output logic [NREG-1:0]      pending,
    output logic                 hilo_busy
);
    stage_t e_s, m_s;
    logic [NSRC-1:0] haz;
    logic [5:0] cnt;
    logic waw, any_stall, set, clr;
    assign e_s = '{dst: e_dst, we: e_we, long: e_long, val: e_val};
    assign m_s = '{dst: m_dst, we: m_we, long: m_long, val: m_val};
    for (genvar i = 0; i < NSRC; i++) begin : g_src
        hazard_fwd #(.BR_FWD_E(BR_FWD_E)) u_fwd (
            .src(d_src[i]), .src_v(d_src_v[i]), .regval(d_regval[i]), .br(d_br),
            .pend(pending[d_src[i]]), .e(e_s), .m(m_s),
            .w_dst(w_dst), .w_we(w_we), .w_val(w_val),
            .val(fwd_val[i]), .haz(haz[i])
        );
    end
    always_comb begin
        hilo_busy = cnt != 6'd0;
        waw = d_we && d_long && pending[d_dst];
        any_stall = (|haz) || waw || (d_hilo && hilo_busy) || ibus_wait;
        // a data-bus wait freezes the whole pipe and drains nothing into W
        stall_f = dbus_wait || any_stall;
        stall_d = dbus_wait || any_stall;
        stall_e = dbus_wait;
        stall_m = dbus_wait;
        bubble_w = dbus_wait;
        bubble_e = !dbus_wait && any_stall;
        set = !stall_d && d_we && d_long && d_dst != 5'd0;
        clr = !dbus_wait && w_we && w_long;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending <= '0;
            cnt <= '0;
        end else begin
            // set is OR-ed after the clear so it wins on a same-register collision
            pending <= (pending & ~(NREG'(clr) << w_dst)) | (NREG'(set) << d_dst);
            cnt <= (mdu_start && !hilo_busy && !dbus_wait) ? 6'(MDU_LAT) : hilo_busy ? cnt - 6'd1 : cnt;
        end
    end
endmodule

// File: tb/tb_hazard_sb.sv
// tb_hazard_sb: directed scenarios plus randomized checking against a rule-level model, two branch-forwarding variants
module tb_hazard_sb;
    localparam int LAT = 4;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;
    logic ibus_wait, dbus_wait, d_br, d_hilo, d_we, d_long, mdu_start;
    logic [1:0][4:0] d_src;
    logic [1:0] d_src_v;
    logic [1:0][31:0] d_regval;
    logic [4:0] d_dst, e_dst, m_dst, w_dst;
    logic e_we, e_long, m_we, m_long, w_we, w_long;
    logic [31:0] e_val, m_val, w_val;
    logic [1:0] sf, sdd, se, sm, be, bw, hb;
    logic [1:0][1:0][31:0] fv;
    logic [1:0][31:0] pd;
    int checks = 0;
    int failures = 0;
    bit [31:0] m_pend [2];
    int m_cnt [2];

    hazard_sb #(.NSRC(2), .MDU_LAT(LAT), .BR_FWD_E(0)) dut0 (
        .clk(clk), .resetn(resetn), .ibus_wait(ibus_wait), .dbus_wait(dbus_wait),
        .d_src(d_src), .d_src_v(d_src_v), .d_regval(d_regval), .d_br(d_br), .d_hilo(d_hilo),
        .d_dst(d_dst), .d_we(d_we), .d_long(d_long), .mdu_start(mdu_start),
        .e_dst(e_dst), .e_we(e_we), .e_long(e_long), .e_val(e_val),
        .m_dst(m_dst), .m_we(m_we), .m_long(m_long), .m_val(m_val),
        .w_dst(w_dst), .w_we(w_we), .w_long(w_long), .w_val(w_val),
        .fwd_val(fv[0]), .stall_f(sf[0]), .stall_d(sdd[0]), .stall_e(se[0]), .stall_m(sm[0]),
        .bubble_e(be[0]), .bubble_w(bw[0]), .pending(pd[0]), .hilo_busy(hb[0])
    );
    hazard_sb #(.NSRC(2), .MDU_LAT(LAT), .BR_FWD_E(1)) dut1 (
        .clk(clk), .resetn(resetn), .ibus_wait(ibus_wait), .dbus_wait(dbus_wait),
        .d_src(d_src), .d_src_v(d_src_v), .d_regval(d_regval), .d_br(d_br), .d_hilo(d_hilo),
        .d_dst(d_dst), .d_we(d_we), .d_long(d_long), .mdu_start(mdu_start),
        .e_dst(e_dst), .e_we(e_we), .e_long(e_long), .e_val(e_val),
        .m_dst(m_dst), .m_we(m_we), .m_long(m_long), .m_val(m_val),
        .w_dst(w_dst), .w_we(w_we), .w_long(w_long), .w_val(w_val),
        .fwd_val(fv[1]), .stall_f(sf[1]), .stall_d(sdd[1]), .stall_e(se[1]), .stall_m(sm[1]),
        .bubble_e(be[1]), .bubble_w(bw[1]), .pending(pd[1]), .hilo_busy(hb[1])
    );

    // control outputs packed as {stall_f, stall_d, stall_e, stall_m, bubble_e, bubble_w}
    function automatic logic [5:0] ctl_of(input int k);
        return {sf[k], sdd[k], se[k], sm[k], be[k], bw[k]};
    endfunction

    task automatic drive_idle();
        ibus_wait = 0; dbus_wait = 0; d_br = 0; d_hilo = 0; d_we = 0; d_long = 0; mdu_start = 0;
        d_src = '0; d_src_v = '0; d_dst = 0;
        d_regval[0] = 32'hAAAA0001; d_regval[1] = 32'hBBBB0002;
        e_dst = 0; e_we = 0; e_long = 0; e_val = 0;
        m_dst = 0; m_we = 0; m_long = 0; m_val = 0;
        w_dst = 0; w_we = 0; w_long = 0; w_val = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // expected outputs derived directly from the forwarding/stall rules
    function automatic void model_out(input int k, output logic [5:0] ctl, output logic [1:0][31:0] fe);
        logic [4:0] sd [3];
        logic swe [3];
        logic slg [3];
        logic [31:0] sv [3];
        logic raw, found, hit, blk, any;
        sd = '{e_dst, m_dst, w_dst};
        swe = '{e_we, m_we, w_we};
        slg = '{e_long, m_long, w_long};
        sv = '{e_val, m_val, w_val};
        raw = 0;
        for (int s = 0; s < 2; s++) begin
            fe[s] = d_regval[s];
            found = 0;
            for (int i = 0; i < 3; i++) begin
                hit = swe[i] && sd[i] == d_src[s] && d_src[s] != 0;
                blk = (i < 2 && slg[i]) || (i == 0 && d_br && k == 0);
                if (hit && !blk && !found) begin
                    fe[s] = sv[i];
                    found = 1;
                end
                if (hit && blk && d_src_v[s]) raw = 1;
            end
            if (d_src_v[s] && d_src[s] != 0 && m_pend[k][d_src[s]] && !(w_we && w_dst == d_src[s])) raw = 1;
        end
        any = raw || (d_we && d_long && m_pend[k][d_dst]) || (d_hilo && m_cnt[k] > 0) || ibus_wait;
        ctl = dbus_wait ? 6'b111101 : any ? 6'b110010 : 6'b000000;
    endfunction

    function automatic void model_step(input int k, input logic stall_d_exp);
        bit [31:0] p;
        p = m_pend[k];
        if (w_we && w_long && !dbus_wait) p[w_dst] = 0;
        if (!stall_d_exp && d_we && d_long && d_dst != 0) p[d_dst] = 1;
        m_pend[k] = p;
        if (mdu_start && m_cnt[k] == 0 && !dbus_wait) m_cnt[k] = LAT;
        else if (m_cnt[k] > 0) m_cnt[k] = m_cnt[k] - 1;
    endfunction

    task automatic test_reset();
        resetn = 0;
        drive_idle();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++; if (ctl_of(k) !== 6'b0) begin failures++; $display("FAIL reset_ctl dut%0d got=%b exp=000000", k, ctl_of(k)); end
            checks++; if (fv[k] !== d_regval) begin failures++; $display("FAIL reset_fwd dut%0d got=%h exp=%h", k, fv[k], d_regval); end
            checks++; if (pd[k] !== 32'h0) begin failures++; $display("FAIL reset_pend dut%0d got=%h exp=0", k, pd[k]); end
            checks++; if (hb[k] !== 1'b0) begin failures++; $display("FAIL reset_busy dut%0d got=%b exp=0", k, hb[k]); end
        end
        d_we = 1; d_long = 1; d_dst = 5; mdu_start = 1;
        tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++; if (pd[k] !== 32'h0) begin failures++; $display("FAIL reset_hold_pend dut%0d got=%h exp=0", k, pd[k]); end
            checks++; if (hb[k] !== 1'b0) begin failures++; $display("FAIL reset_hold_busy dut%0d got=%b exp=0", k, hb[k]); end
        end
        drive_idle();
        resetn = 1;
        tick();
    endtask

    task automatic test_fwd_priority();
        logic [31:0] exp_v [3];
        exp_v = '{32'h11, 32'h22, 32'h33};
        for (int c = 0; c < 3; c++) begin
            drive_idle();
            d_src[0] = 5; d_src_v = 2'b01;
            e_dst = 5; e_we = (c < 1); e_val = 32'h11;
            m_dst = 5; m_we = (c < 2); m_val = 32'h22;
            w_dst = 5; w_we = 1; w_val = 32'h33;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++; if (fv[k][0] !== exp_v[c]) begin failures++; $display("FAIL fwd_prio%0d dut%0d got=%h exp=%h", c, k, fv[k][0], exp_v[c]); end
                checks++; if (ctl_of(k) !== 6'b0) begin failures++; $display("FAIL fwd_prio%0d_ctl dut%0d got=%b exp=000000", c, k, ctl_of(k)); end
            end
            tick();
        end
        drive_idle();
        d_src_v = 2'b11;
        e_we = 1; e_long = 1; e_val = 32'h11;
        m_we = 1; m_long = 1; m_val = 32'h22;
        w_we = 1; w_val = 32'h33;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++; if (fv[k] !== d_regval) begin failures++; $display("FAIL fwd_r0 dut%0d got=%h exp=%h", k, fv[k], d_regval); end
            checks++; if (ctl_of(k) !== 6'b0) begin failures++; $display("FAIL fwd_r0_ctl dut%0d got=%b exp=000000", k, ctl_of(k)); end
        end
        tick();
    endtask

    task automatic test_load_use();
        drive_idle();
        d_we = 1; d_long = 1; d_dst = 7;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++; if (ctl_of(k) !== 6'b0) begin failures++; $display("FAIL lu_issue dut%0d got=%b exp=000000", k, ctl_of(k)); end
        end
        tick();
        for (int c = 1; c < 3; c++) begin
            drive_idle();
            d_src[0] = 7; d_src_v = 2'b01;
            if (c == 1) begin e_dst = 7; e_we = 1; e_long = 1; end
            else begin m_dst = 7; m_we = 1; m_long = 1; end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++; if (ctl_of(k) !== 6'b110010) begin failures++; $display("FAIL lu_stall%0d dut%0d got=%b exp=110010", c, k, ctl_of(k)); end
                checks++; if (pd[k] !== 32'h80) begin failures++; $display("FAIL lu_pend%0d dut%0d got=%h exp=80", c, k, pd[k]); end
            end
            tick();
        end
        drive_idle();
        d_src[0] = 7; d_src_v = 2'b01;
        w_dst = 7; w_we = 1; w_long = 1; w_val = 32'hCAFE0007;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++; if (ctl_of(k) !== 6'b0) begin failures++; $display("FAIL lu_release dut%0d got=%b exp=000000", k, ctl_of(k)); end
            checks++; if (fv[k][0] !== 32'hCAFE0007) begin failures++; $display("FAIL lu_fwd_w dut%0d got=%h exp=cafe0007", k, fv[k][0]); end
        end
        tick();
        drive_idle();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++; if (pd[k] !== 32'h0) begin failures++; $display("FAIL lu_clear dut%0d got=%h exp=0", k, pd[k]); end
        end
        tick();
    endtask

    task automatic test_waw();
        drive_idle();
        d_we = 1; d_long = 1; d_dst = 9;
        tick();
        for (int c = 1; c < 4; c++) begin
            drive_idle();
            d_we = 1; d_long = 1; d_dst = 9;
            if (c == 1) begin e_dst = 9; e_we = 1; e_long = 1; end
            if (c == 2) begin m_dst = 9; m_we = 1; m_long = 1; end
            if (c == 3) begin w_dst = 9; w_we = 1; w_long = 1; end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++; if (ctl_of(k) !== 6'b110010) begin failures++; $display("FAIL waw_hold%0d dut%0d got=%b exp=110010", c, k, ctl_of(k)); end
            end
            tick();
        end
        drive_idle();
        d_we = 1; d_long = 1; d_dst = 9;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++; if (ctl_of(k) !== 6'b0) begin failures++; $display("FAIL waw_go dut%0d got=%b exp=000000", k, ctl_of(k)); end
            checks++; if (pd[k] !== 32'h0) begin failures++; $display("FAIL waw_cleared dut%0d got=%h exp=0", k, pd[k]); end
        end
        tick();
        drive_idle();
        w_dst = 9; w_we = 1; w_long = 1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++; if (pd[k] !== 32'h200) begin failures++; $display("FAIL waw_reset dut%0d got=%h exp=200", k, pd[k]); end
        end
        tick();
        drive_idle();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++; if (pd[k] !== 32'h0) begin failures++; $display("FAIL waw_final dut%0d got=%h exp=0", k, pd[k]); end
        end
        tick();
    endtask

    task automatic test_mdu();
        drive_idle();
        mdu_start = 1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++; if (hb[k] !== 1'b0) begin failures++; $display("FAIL mdu_idle dut%0d got=%b exp=0", k, hb[k]); end
        end
        tick();
        for (int c = 1; c <= LAT; c++) begin
            drive_idle();
            d_hilo = 1;
            mdu_start = (c == 2);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++; if (hb[k] !== 1'b1) begin failures++; $display("FAIL mdu_busy%0d dut%0d got=%b exp=1", c, k, hb[k]); end
                checks++; if (ctl_of(k) !== 6'b110010) begin failures++; $display("FAIL mdu_stall%0d dut%0d got=%b exp=110010", c, k, ctl_of(k)); end
            end
            tick();
        end
        drive_idle();
        d_hilo = 1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++; if (hb[k] !== 1'b0) begin failures++; $display("FAIL mdu_done dut%0d got=%b exp=0", k, hb[k]); end
            checks++; if (ctl_of(k) !== 6'b0) begin failures++; $display("FAIL mdu_release dut%0d got=%b exp=000000", k, ctl_of(k)); end
        end
        tick();
    endtask

    task automatic test_branch();
        drive_idle();
        d_br = 1; d_src[0] = 3; d_src_v = 2'b01;
        e_dst = 3; e_we = 1; e_val = 32'h33;
        @(negedge clk);
        checks++; if (ctl_of(0) !== 6'b110010) begin failures++; $display("FAIL br_e_stall dut0 got=%b exp=110010", ctl_of(0)); end
        checks++; if (ctl_of(1) !== 6'b0) begin failures++; $display("FAIL br_e_fwd_ctl dut1 got=%b exp=000000", ctl_of(1)); end
        checks++; if (fv[1][0] !== 32'h33) begin failures++; $display("FAIL br_e_fwd_val dut1 got=%h exp=33", fv[1][0]); end
        tick();
        drive_idle();
        d_br = 1; d_src[0] = 3; d_src_v = 2'b01;
        m_dst = 3; m_we = 1; m_val = 32'h33;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++; if (ctl_of(k) !== 6'b0) begin failures++; $display("FAIL br_m_ctl dut%0d got=%b exp=000000", k, ctl_of(k)); end
            checks++; if (fv[k][0] !== 32'h33) begin failures++; $display("FAIL br_m_val dut%0d got=%h exp=33", k, fv[k][0]); end
        end
        tick();
    endtask

    task automatic test_dbus_raw();
        drive_idle();
        d_we = 1; d_long = 1; d_dst = 7;
        tick();
        for (int c = 1; c < 4; c++) begin
            drive_idle();
            dbus_wait = 1; ibus_wait = (c == 2);
            d_src[0] = 7; d_src_v = 2'b01;
            d_we = 1; d_long = 1; d_dst = 20;
            e_dst = 7; e_we = 1; e_long = 1;
            w_dst = 7; w_we = 1; w_long = 1;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++; if (ctl_of(k) !== 6'b111101) begin failures++; $display("FAIL dbus_ctl%0d dut%0d got=%b exp=111101", c, k, ctl_of(k)); end
                checks++; if (pd[k] !== 32'h80) begin failures++; $display("FAIL dbus_pend%0d dut%0d got=%h exp=80", c, k, pd[k]); end
            end
            tick();
        end
        drive_idle();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++; if (pd[k] !== 32'h80) begin failures++; $display("FAIL dbus_after dut%0d got=%h exp=80", k, pd[k]); end
            checks++; if (ctl_of(k) !== 6'b0) begin failures++; $display("FAIL dbus_after_ctl dut%0d got=%b exp=000000", k, ctl_of(k)); end
        end
        tick();
    endtask

    task automatic test_ibus();
        drive_idle();
        ibus_wait = 1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++; if (ctl_of(k) !== 6'b110010) begin failures++; $display("FAIL ibus_ctl dut%0d got=%b exp=110010", k, ctl_of(k)); end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        drive_idle();
        d_we = 1; d_long = 1; d_dst = 4; mdu_start = 1;
        tick();
        drive_idle();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++; if (pd[k] !== 32'h90) begin failures++; $display("FAIL rmid_pre_pend dut%0d got=%h exp=90", k, pd[k]); end
            checks++; if (hb[k] !== 1'b1) begin failures++; $display("FAIL rmid_pre_busy dut%0d got=%b exp=1", k, hb[k]); end
        end
        resetn = 0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (pd[k] !== 32'h0) begin failures++; $display("FAIL rmid_async_pend dut%0d got=%h exp=0", k, pd[k]); end
            checks++; if (hb[k] !== 1'b0) begin failures++; $display("FAIL rmid_async_busy dut%0d got=%b exp=0", k, hb[k]); end
        end
        @(negedge clk);
        resetn = 1;
        tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++; if (ctl_of(k) !== 6'b0) begin failures++; $display("FAIL rmid_clean_ctl dut%0d got=%b exp=000000", k, ctl_of(k)); end
            checks++; if (pd[k] !== 32'h0 || hb[k] !== 1'b0) begin failures++; $display("FAIL rmid_clean_state dut%0d got=%h/%b exp=0/0", k, pd[k], hb[k]); end
        end
        tick();
    endtask

    task automatic test_random();
        logic [5:0] ectl;
        logic [1:0][31:0] efv;
        drive_idle();
        resetn = 0;
        @(negedge clk);
        resetn = 1;
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = '0;
            m_cnt[k] = 0;
        end
        tick();
        for (int n = 0; n < 400; n++) begin
            ibus_wait = ($urandom_range(0, 7) == 0);
            dbus_wait = ($urandom_range(0, 7) == 0);
            d_br = $urandom_range(0, 1);
            d_hilo = ($urandom_range(0, 2) == 0);
            mdu_start = ($urandom_range(0, 5) == 0);
            for (int s = 0; s < 2; s++) begin
                d_src[s] = 5'($urandom_range(0, 3));
                d_regval[s] = $urandom;
            end
            d_src_v = 2'($urandom_range(0, 3));
            d_dst = 5'($urandom_range(0, 3)); d_we = $urandom_range(0, 1); d_long = $urandom_range(0, 1);
            e_dst = 5'($urandom_range(0, 3)); e_we = $urandom_range(0, 1); e_long = $urandom_range(0, 1); e_val = $urandom;
            m_dst = 5'($urandom_range(0, 3)); m_we = $urandom_range(0, 1); m_long = $urandom_range(0, 1); m_val = $urandom;
            w_dst = 5'($urandom_range(0, 3)); w_we = $urandom_range(0, 1); w_long = $urandom_range(0, 1); w_val = $urandom;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                model_out(k, ectl, efv);
                checks++; if (ctl_of(k) !== ectl) begin failures++; $display("FAIL rnd_ctl n=%0d dut%0d got=%b exp=%b", n, k, ctl_of(k), ectl); end
                checks++; if (fv[k] !== efv) begin failures++; $display("FAIL rnd_fwd n=%0d dut%0d got=%h exp=%h", n, k, fv[k], efv); end
                checks++; if (pd[k] !== m_pend[k]) begin failures++; $display("FAIL rnd_pend n=%0d dut%0d got=%h exp=%h", n, k, pd[k], m_pend[k]); end
                checks++; if (hb[k] !== (m_cnt[k] != 0)) begin failures++; $display("FAIL rnd_busy n=%0d dut%0d got=%b exp=%b", n, k, hb[k], m_cnt[k] != 0); end
                model_step(k, ectl[4]);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_fwd_priority();
        test_load_use();
        test_waw();
        test_mdu();
        test_branch();
        test_dbus_raw();
        test_ibus();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
